// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state type, default width and duty stepping helper for the PWM ramp controller
//
// Contents:
//   ramp_state_t - controller state (IDLE, RAMP_UP, RAMP_DOWN), 2-bit encoding
//   DEFAULT_N    - default duty/period counter width
//   CLAMP_W      - working width of clamp_step (callers zero-extend into it)
//   clamp_step   - next duty one bounded step from cur toward tgt
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

    localparam int DEFAULT_N = 3;
    localparam int CLAMP_W   = 16;

    // The distance is taken one bit wider than the operands so it can never
    // wrap; when the remaining distance is not larger than the step, the
    // result lands exactly on the target instead of overshooting it.
    function automatic logic [CLAMP_W-1:0] clamp_step(
        input logic [CLAMP_W-1:0] cur,
        input logic [CLAMP_W-1:0] tgt,
        input logic [CLAMP_W-1:0] step
    );
        logic [CLAMP_W:0]   diff;
        logic [CLAMP_W-1:0] nxt;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            nxt  = (diff > {1'b0, step}) ? cur + step : tgt;
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            nxt  = (diff > {1'b0, step}) ? cur - step : tgt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/pwm_ramp_controller_period_counter.sv
// rtl/pwm_ramp_controller_period_counter.sv - free-running PWM period counter with boundary and period-start flags
//
// Module pwm_period_counter, reusable for aligning other PWM channels.
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = count, 0 = hold
//   cnt          out  N-bit period position, wraps 2**N-1 -> 0
//   boundary     out  enable && cnt == 2**N-1 (last clock of a period)
//   period_start out  enable && cnt == 0 (first clock of a period)
module pwm_period_counter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic [N-1:0] cnt,
    output logic         boundary,
    output logic         period_start
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + N'(1);
        end
    end

    assign boundary     = enable && (cnt == {N{1'b1}});
    assign period_start = enable && (cnt == '0);

endmodule

// File: rtl/pwm_ramp_controller.sv
// rtl/pwm_ramp_controller.sv - ramps the PWM duty toward an accepted target in bounded, period-aligned steps
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = period counter runs and ramp may advance, 0 = freeze
//   target_duty  in   N-bit requested duty, sampled on handshake
//   target_valid in   target_duty is valid
//   target_ready out  controller can accept a target (IDLE only)
//   duty_cycle   out  registered duty for the PWM generator
//   period_start out  enable && period counter == 0
//   busy         out  ramp in progress
//   done         out  one-cycle pulse once duty_cycle equals the accepted target
module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter int N            = DEFAULT_N,
    parameter int STEP         = 1,
    parameter int STEP_PERIODS = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] target_duty,
    input  logic         target_valid,
    output logic         target_ready,
    output logic [N-1:0] duty_cycle,
    output logic         period_start,
    output logic         busy,
    output logic         done
);

    localparam int              SC_W      = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [SC_W-1:0] STEP_LAST = SC_W'(STEP_PERIODS - 1);

    ramp_state_t     state, state_n;
    logic [N-1:0]    target_q, target_n;
    logic [N-1:0]    duty_n;
    logic [N-1:0]    stepped;
    logic [SC_W-1:0] step_cnt, step_n;
    logic            done_n;
    logic            boundary;
    // Only boundary/period_start are needed here; the raw count is left for
    // other channels that share the same counter module.
    logic [N-1:0]    cnt_unused;

    pwm_period_counter #(
        .N(N)
    ) u_period (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .cnt          (cnt_unused),
        .boundary     (boundary),
        .period_start (period_start)
    );

    assign stepped = N'(clamp_step(CLAMP_W'(duty_cycle), CLAMP_W'(target_q), CLAMP_W'(STEP)));

    always_comb begin
        state_n  = state;
        target_n = target_q;
        duty_n   = duty_cycle;
        step_n   = step_cnt;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                // Acceptance never touches duty_cycle, so a running period
                // keeps its duty; the ramp only moves on later boundaries.
                if (target_valid) begin
                    target_n = target_duty;
                    step_n   = '0;
                    if (target_duty == duty_cycle) begin
                        done_n = 1'b1;
                    end else if (target_duty > duty_cycle) begin
                        state_n = RAMP_UP;
                    end else begin
                        state_n = RAMP_DOWN;
                    end
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (boundary) begin
                    if (step_cnt == STEP_LAST) begin
                        step_n = '0;
                        duty_n = stepped;
                        if (stepped == target_q) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end
                    end else begin
                        step_n = step_cnt + SC_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            target_q   <= '0;
            duty_cycle <= '0;
            step_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            target_q   <= target_n;
            duty_cycle <= duty_n;
            step_cnt   <= step_n;
            done       <= done_n;
        end
    end

    assign target_ready = (state == IDLE);
    assign busy         = (state == RAMP_UP) || (state == RAMP_DOWN);

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// tb/tb_pwm_ramp_controller.sv - randomized self-checking bench for pwm_ramp_controller (STEP=1 and STEP=3 instances)
module tb_pwm_ramp_controller;

    localparam int N   = 3;
    localparam int SP  = 2;
    localparam int PER = 1 << N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i   [2];
    logic         en_i    [2];
    logic         tv_i    [2];
    logic [N-1:0] td_i    [2];
    logic [N-1:0] duty_o  [2];
    logic         ready_o [2];
    logic         ps_o    [2];
    logic         busy_o  [2];
    logic         done_o  [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: period position, and the ramp as a closed form of
    // boundaries seen since acceptance.
    int m_cnt [2];
    int m_duty[2];
    int m_d0  [2];
    int m_tgt [2];
    int m_nb  [2];
    bit m_idle[2];
    bit m_done[2];

    pwm_ramp_controller #(.N(N), .STEP(1), .STEP_PERIODS(SP)) dut (
        .clk          (clk),
        .reset        (rst_i[0]),
        .enable       (en_i[0]),
        .target_duty  (td_i[0]),
        .target_valid (tv_i[0]),
        .target_ready (ready_o[0]),
        .duty_cycle   (duty_o[0]),
        .period_start (ps_o[0]),
        .busy         (busy_o[0]),
        .done         (done_o[0])
    );

    pwm_ramp_controller #(.N(N), .STEP(3), .STEP_PERIODS(SP)) dut3 (
        .clk          (clk),
        .reset        (rst_i[1]),
        .enable       (en_i[1]),
        .target_duty  (td_i[1]),
        .target_valid (tv_i[1]),
        .target_ready (ready_o[1]),
        .duty_cycle   (duty_o[1]),
        .period_start (ps_o[1]),
        .busy         (busy_o[1]),
        .done         (done_o[1])
    );

    function automatic int step_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int i);
        m_cnt[i]  = 0;
        m_duty[i] = 0;
        m_d0[i]   = 0;
        m_tgt[i]  = 0;
        m_nb[i]   = 0;
        m_idle[i] = 1'b1;
        m_done[i] = 1'b0;
    endtask

    task automatic model_edge(input int i);
        int mag;
        int moved;
        bit bnd;
        bit dn;
        if (rst_i[i]) begin
            model_reset(i);
            return;
        end
        bnd = en_i[i] && (m_cnt[i] == PER - 1);
        dn  = 1'b0;
        if (m_idle[i]) begin
            if (tv_i[i]) begin
                m_d0[i]  = m_duty[i];
                m_tgt[i] = int'(td_i[i]);
                m_nb[i]  = 0;
                if (m_tgt[i] == m_duty[i]) dn = 1'b1;
                else m_idle[i] = 1'b0;
            end
        end else if (bnd) begin
            m_nb[i]++;
            mag   = (m_tgt[i] >= m_d0[i]) ? m_tgt[i] - m_d0[i] : m_d0[i] - m_tgt[i];
            moved = (m_nb[i] / SP) * step_of(i);
            if (moved > mag) moved = mag;
            m_duty[i] = (m_tgt[i] >= m_d0[i]) ? m_d0[i] + moved : m_d0[i] - moved;
            if (m_duty[i] == m_tgt[i]) begin
                m_idle[i] = 1'b1;
                dn        = 1'b1;
            end
        end
        if (en_i[i]) m_cnt[i] = (m_cnt[i] + 1) % PER;
        m_done[i] = dn;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_edge(i);
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("duty%0d", i),  int'(duty_o[i]),  m_duty[i]);
            check_eq($sformatf("busy%0d", i),  int'(busy_o[i]),  int'(!m_idle[i]));
            check_eq($sformatf("ready%0d", i), int'(ready_o[i]), int'(m_idle[i]));
            check_eq($sformatf("done%0d", i),  int'(done_o[i]),  int'(m_done[i]));
            check_eq($sformatf("pstart%0d", i), int'(ps_o[i]),
                     int'(en_i[i] && (m_cnt[i] == 0)));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(input int i, input int v);
        tv_i[i] = 1'b1;
        td_i[i] = N'(v);
        cyc(1);
        tv_i[i] = 1'b0;
    endtask

    // Runs until the model reports idle; optional target_valid noise (value
    // nv, or random when nv<0) and random enable drops while ramping.
    task automatic ramp_wait(input int i, input bit noise, input int nv, input bit en_rand, input int budget);
        int k;
        k = 0;
        while (!m_idle[i] && k < budget) begin
            if (noise) begin
                tv_i[i] = ($urandom_range(0, 3) == 0);
                td_i[i] = (nv < 0) ? N'($urandom_range(0, PER - 1)) : N'(nv);
            end
            if (en_rand) en_i[i] = ($urandom_range(0, 3) != 0);
            cyc(1);
            k++;
        end
        tv_i[i] = 1'b0;
        en_i[i] = 1'b1;
        check_eq($sformatf("ramp_timeout%0d", i), int'(m_idle[i]), 1);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            rst_i[i] = 1'b1;
            en_i[i]  = 1'b0;
            tv_i[i]  = 1'b0;
            td_i[i]  = '0;
        end
        cyc(3);
        rst_i[0] = 1'b0;
        rst_i[1] = 1'b0;
        cyc(2);
        en_i[0] = 1'b1;
        en_i[1] = 1'b1;
        cyc(20);

        // ramp up 0 -> 3
        send(0, 3);
        check_eq("accept_ready", int'(ready_o[0]), 0);
        check_eq("accept_busy", int'(busy_o[0]), 1);
        ramp_wait(0, 1'b0, 0, 1'b0, 200);
        check_eq("up_final", int'(duty_o[0]), 3);

        // ramp down 7 -> 2 with ignored target 5 pulses
        send(0, 7);
        ramp_wait(0, 1'b0, 0, 1'b0, 300);
        send(0, 2);
        ramp_wait(0, 1'b1, 5, 1'b0, 300);
        check_eq("down_final", int'(duty_o[0]), 2);

        // same target: no busy, single done pulse
        cyc(3);
        send(0, 2);
        check_eq("same_done", int'(done_o[0]), 1);
        check_eq("same_busy", int'(busy_o[0]), 0);
        cyc(1);
        check_eq("same_done_end", int'(done_o[0]), 0);

        // freeze mid-ramp 0 -> 4
        send(0, 0);
        ramp_wait(0, 1'b0, 0, 1'b0, 300);
        send(0, 4);
        cyc(20);
        en_i[0] = 1'b0;
        cyc(20);
        en_i[0] = 1'b1;
        ramp_wait(0, 1'b0, 0, 1'b0, 300);
        check_eq("freeze_final", int'(duty_o[0]), 4);

        // STEP=3: 0 -> 7 saturating, then asynchronous reset mid-ramp
        send(1, 7);
        ramp_wait(1, 1'b0, 0, 1'b0, 300);
        check_eq("sat_final", int'(duty_o[1]), 7);
        send(1, 0);
        cyc(4);
        check_eq("pre_reset", int'(duty_o[1]), 7);
        #1;
        rst_i[1] = 1'b1;
        model_reset(1);
        #1;
        check_eq("async_duty", int'(duty_o[1]), 0);
        check_eq("async_ready", int'(ready_o[1]), 1);
        check_eq("async_busy", int'(busy_o[1]), 0);
        cyc(2);
        rst_i[1] = 1'b0;
        cyc(3);

        // randomized targets, noise and enable drops on both instances
        repeat (30) begin
            for (int i = 0; i < 2; i++) begin
                send(i, int'($urandom_range(0, PER - 1)));
                ramp_wait(i, 1'b1, -1, 1'b1, 800);
                cyc(int'($urandom_range(0, 5)));
            end
        end

        cyc(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
